// File: rtl/instr_fetch_pkg.sv
// Shared CPU package for the instruction fetch unit:
// fetch FSM encoding and the fetch parameter defaults.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned TIMEOUT_DEF  = 16;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus between fetch (master)
// and the instruction memory (slave).
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/instr_fetch_timer.sv
// Wait counter for an outstanding memory request;
// flags expiry once TIMEOUT un-acked cycles are reached.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  // clear on a new request, count each un-acked cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding request,
// flush/drain handling, decode hand-off and timeout.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          next_pc,
  input  logic                 flush,
  input  logic                 dec_ready,
  instr_fetch_if.master        imem,
  output logic [31:0]          pc,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic                 fetch_err,
  output logic [31:0]          instr_count
);

  fetch_state_t state_q, state_n;

  logic [31:0] pc_q, pc_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] count_q, count_n;
  logic        req_q, req_n;
  logic        valid_q, valid_n;
  logic        err_q, err_n;

  logic ack;
  logic clr;
  logic run;
  logic expired;

  // an ack only counts against a request we raised
  assign ack = imem.imem_ack & req_q;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .run     (run),
    .expired (expired)
  );

  // next-state and next-output decode
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    addr_n  = addr_q;
    instr_n = instr_q;
    count_n = count_q;
    req_n   = req_q;
    valid_n = valid_q;
    err_n   = err_q;
    clr     = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      REQ: begin
        if (!req_q) begin
          // first cycle out of reset: nothing
          // outstanding yet, so a flush just
          // retargets the request
          req_n = 1'b1;
          clr   = 1'b1;
          if (flush) begin
            pc_n   = next_pc;
            addr_n = next_pc;
          end
        end else if (flush && ack) begin
          pc_n   = next_pc;
          addr_n = next_pc;
          clr    = 1'b1;
        end else if (flush) begin
          pc_n    = next_pc;
          state_n = DRAIN;
          clr     = 1'b1;
        end else if (ack) begin
          instr_n = imem.imem_rdata;
          valid_n = 1'b1;
          req_n   = 1'b0;
          state_n = HOLD;
        end else if (expired) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          run = 1'b1;
        end
      end
      HOLD: begin
        if (flush || dec_ready) begin
          pc_n    = next_pc;
          addr_n  = next_pc;
          valid_n = 1'b0;
          req_n   = 1'b1;
          clr     = 1'b1;
          state_n = REQ;
          if (!flush) begin
            count_n = count_q + 32'd1;
          end
        end
      end
      DRAIN: begin
        if (ack) begin
          pc_n    = flush ? next_pc : pc_q;
          addr_n  = pc_n;
          clr     = 1'b1;
          state_n = REQ;
        end else if (expired) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          run = 1'b1;
          if (flush) begin
            pc_n = next_pc;
          end
        end
      end
      ERR: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
        err_n   = 1'b1;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      instr_q <= instr_n;
      count_q <= count_n;
      req_q   <= req_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign fetch_err      = err_q;
  assign instr_count    = count_q;

endmodule
